// File: rtl/pio_edge_service_ctrl_if.sv
// Avalon-MM link between the edge servicer (master) and the 4-bit edge-capturing PIO slave port.
interface pio_edge_service_ctrl_if;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata;
    logic        pio_irq;

    modport master (
        output pio_address, pio_chipselect, pio_write_n, pio_writedata,
        input  pio_readdata, pio_irq
    );

    modport slave (
        input  pio_address, pio_chipselect, pio_write_n, pio_writedata,
        output pio_readdata, pio_irq
    );
endinterface

// File: rtl/pio_edge_service_ctrl.sv
// Hardware PIO edge-interrupt servicer: programs irq_mask, drains edge_capture into a show-ahead FIFO.
// Optional PIO_SVC_TIMESTAMP_EN appends a 16-bit cycle timestamp (taken in RD_CAP) to each event.
module pio_edge_service_ctrl #(
    parameter int                DATA_W     = 4,
    parameter logic [DATA_W-1:0] INIT_MASK  = 4'hF,
    parameter int                FIFO_DEPTH = 8,
`ifdef PIO_SVC_TIMESTAMP_EN
    localparam int               EVT_W      = 2*DATA_W + 16
`else
    localparam int               EVT_W      = 2*DATA_W
`endif
) (
    input  logic                    clk,
    input  logic                    reset_n,
    pio_edge_service_ctrl_if.master pio,
    input  logic [DATA_W-1:0]       cfg_mask,
    input  logic                    cfg_mask_wr,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [EVT_W-1:0]        evt_data,
    output logic                    busy
);

    localparam int               AW      = $clog2(FIFO_DEPTH);
    localparam int               CW      = AW + 1;
    localparam logic [CW-1:0]    DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_INIT, S_CLR0, S_IDLE, S_CFG, S_RD_CAP, S_RD_LVL, S_CLR, S_PUSH
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] active_mask;
    logic [DATA_W-1:0] cfg_pend;
    logic              cfg_pend_vld;
    logic [DATA_W-1:0] cap_reg;
    logic [DATA_W-1:0] lvl_reg;

    logic [EVT_W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     fifo_count;
    logic              push;
    logic              pop;
    logic [EVT_W-1:0]  push_data;
    logic              unused_rd;

    assign unused_rd = ^pio.pio_readdata;

    // NOTE: every register update uses <= so all state advances together on the edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= S_INIT;
            active_mask  <= INIT_MASK;
            cfg_pend     <= '0;
            cfg_pend_vld <= 1'b0;
            cap_reg      <= '0;
            lvl_reg      <= '0;
        end else begin
            if (cfg_mask_wr) cfg_pend <= cfg_mask;
            // A request arriving in the CFG cycle itself stays pending for the next pass.
            if (cfg_mask_wr)          cfg_pend_vld <= 1'b1;
            else if (state == S_CFG)  cfg_pend_vld <= 1'b0;

            case (state)
                S_INIT:   state <= S_CLR0;
                S_CLR0:   state <= S_IDLE;
                S_IDLE: begin
                    if (cfg_pend_vld)                                state <= S_CFG;
                    else if (pio.pio_irq && (fifo_count < DEPTH_C))  state <= S_RD_CAP;
                end
                S_CFG: begin
                    active_mask <= cfg_pend;
                    state       <= S_IDLE;
                end
                S_RD_CAP: state <= S_RD_LVL;
                S_RD_LVL: begin
                    cap_reg <= pio.pio_readdata[DATA_W-1:0] & active_mask;
                    state   <= S_CLR;
                end
                S_CLR: begin
                    lvl_reg <= pio.pio_readdata[DATA_W-1:0];
                    state   <= S_PUSH;
                end
                S_PUSH:   state <= S_IDLE;
                default:  state <= S_INIT;
            endcase
        end
    end

    // Bus strobes are forced idle while reset is held, so the INIT write appears on release.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch behind.
        pio.pio_address    = 2'd0;
        pio.pio_chipselect = 1'b0;
        pio.pio_write_n    = 1'b1;
        pio.pio_writedata  = '0;
        if (reset_n) begin
            case (state)
                S_INIT: begin
                    pio.pio_address    = 2'd2;
                    pio.pio_chipselect = 1'b1;
                    pio.pio_write_n    = 1'b0;
                    pio.pio_writedata  = 32'(INIT_MASK);
                end
                S_CFG: begin
                    pio.pio_address    = 2'd2;
                    pio.pio_chipselect = 1'b1;
                    pio.pio_write_n    = 1'b0;
                    pio.pio_writedata  = 32'(cfg_pend);
                end
                S_CLR0, S_CLR: begin
                    pio.pio_address    = 2'd3;
                    pio.pio_chipselect = 1'b1;
                    pio.pio_write_n    = 1'b0;
                end
                S_RD_CAP: begin
                    pio.pio_address    = 2'd3;
                    pio.pio_chipselect = 1'b1;
                end
                S_RD_LVL: begin
                    pio.pio_chipselect = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

`ifdef PIO_SVC_TIMESTAMP_EN
    logic [15:0] ts_cnt;
    logic [15:0] ts_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ts_cnt <= '0;
            ts_reg <= '0;
        end else begin
            ts_cnt <= ts_cnt + 16'd1;
            if (state == S_RD_CAP) ts_reg <= ts_cnt;
        end
    end

    assign push_data = {cap_reg, lvl_reg, ts_reg};
`else
    assign push_data = {cap_reg, lvl_reg};
`endif

    // Spurious irqs (all captured bits masked off) complete the service without an entry.
    assign push      = (state == S_PUSH) && (cap_reg != '0);
    assign pop       = evt_valid && evt_ready;
    assign evt_valid = (fifo_count != '0);
    assign evt_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage is deliberately left unreset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: tb/tb_pio_edge_service_ctrl.sv
// Self-checking bench: behavioural PIO slave plus an expected-event queue built from the input edges.
module tb_pio_edge_service_ctrl;

    localparam int DATA_W     = 4;
    localparam int FIFO_DEPTH = 8;
`ifdef PIO_SVC_TIMESTAMP_EN
    localparam int EVT_W = 2*DATA_W + 16;
`else
    localparam int EVT_W = 2*DATA_W;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [DATA_W-1:0] cfg_mask = '0;
    logic              cfg_mask_wr = 1'b0;
    logic              evt_ready = 1'b0;
    logic              evt_valid;
    logic              busy;
    logic [EVT_W-1:0]  evt_data;

    always #5 clk = ~clk;

    pio_edge_service_ctrl_if pio_bus ();

    pio_edge_service_ctrl #(
        .DATA_W     (DATA_W),
        .INIT_MASK  (4'hF),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pio         (pio_bus),
        .cfg_mask    (cfg_mask),
        .cfg_mask_wr (cfg_mask_wr),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_data    (evt_data),
        .busy        (busy)
    );

    // PIO slave model: rising-edge capture, write-clear wins, registered readdata.
    logic [3:0]  in_port  = '0;
    logic [3:0]  in_d     = '0;
    logic [3:0]  edge_cap = '0;
    logic [3:0]  irq_mask = '0;
    logic [31:0] rdata    = '0;
    logic [33:0] wr_log [$];

    assign pio_bus.pio_readdata = rdata;
    assign pio_bus.pio_irq      = |(edge_cap & irq_mask);

    always @(posedge clk) begin
        in_d <= in_port;
        if (pio_bus.pio_chipselect && !pio_bus.pio_write_n) begin
            wr_log.push_back({pio_bus.pio_address, pio_bus.pio_writedata});
            if (pio_bus.pio_address == 2'd2) irq_mask <= pio_bus.pio_writedata[3:0];
        end
        if (pio_bus.pio_chipselect && !pio_bus.pio_write_n && pio_bus.pio_address == 2'd3)
            edge_cap <= '0;
        else
            edge_cap <= edge_cap | (in_port & ~in_d);
        case (pio_bus.pio_address)
            2'd0:    rdata <= {28'd0, in_port};
            2'd2:    rdata <= {28'd0, irq_mask};
            2'd3:    rdata <= {28'd0, edge_cap};
            default: rdata <= '0;
        endcase
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [2*DATA_W-1:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive_in(input logic [3:0] v);
        @(posedge clk);
        #1 in_port = v;
    endtask

    task automatic pop_check(input string tag, output logic [EVT_W-1:0] got);
        bit seen;
        seen = 1'b0;
        got  = '0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = evt_valid;
        end
        check({tag, "_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            got = evt_data;
            check({tag, "_expected"}, 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0)
                check(tag, 64'(evt_data[EVT_W-1 -: 2*DATA_W]), 64'(exp_q.pop_front()));
            evt_ready = 1'b1;
            @(posedge clk);
            #1 evt_ready = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [EVT_W-1:0] got;
        logic [3:0]       old_lvl, new_lvl, edges, b;
        int               irq_cyc, val_cyc, seen_cnt;
        bit               found;

        // Reset held for two edges: defaults on the bus, busy high, FIFO empty.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  64'(busy), 64'd1);
        check("rst_valid", 64'(evt_valid), 64'd0);
        check("rst_cs",    64'(pio_bus.pio_chipselect), 64'd0);
        check("rst_wn",    64'(pio_bus.pio_write_n), 64'd1);
        check("rst_addr",  64'(pio_bus.pio_address), 64'd0);
        check("rst_wd",    64'(pio_bus.pio_writedata), 64'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        @(negedge clk);
        check("init_wr",   64'({pio_bus.pio_chipselect, pio_bus.pio_write_n, pio_bus.pio_address}), 64'({1'b1, 1'b0, 2'd2}));
        check("init_data", 64'(pio_bus.pio_writedata), 64'hF);
        @(negedge clk);
        check("clr0_wr",   64'({pio_bus.pio_chipselect, pio_bus.pio_write_n, pio_bus.pio_address}), 64'({1'b1, 1'b0, 2'd3}));
        check("clr0_data", 64'(pio_bus.pio_writedata), 64'd0);
        @(negedge clk);
        check("idle_busy",  64'(busy), 64'd0);
        check("idle_valid", 64'(evt_valid), 64'd0);
        check("pio_mask_init", 64'(irq_mask), 64'hF);

        // Single rising edge on bit1: event 5 cycles after irq is seen in IDLE.
        drive_in(4'b0010);
        exp_q.push_back({4'b0010, 4'b0010});
        irq_cyc = -1;
        val_cyc = -1;
        for (int i = 0; i < 20 && val_cyc < 0; i++) begin
            @(negedge clk);
            if (irq_cyc < 0 && pio_bus.pio_irq && !busy) irq_cyc = i;
            if (evt_valid) val_cyc = i;
        end
        check("latency_seen", 64'(val_cyc >= 0 && irq_cyc >= 0), 64'd1);
        check("latency", 64'(val_cyc - irq_cyc), 64'd5);
        check("pio_ec_cleared", 64'(edge_cap), 64'd0);
        pop_check("first_evt", got);

        // Randomized level changes; only rising bits form an event.
        for (int n = 0; n < 16; n++) begin
            old_lvl = in_port;
            new_lvl = 4'($urandom_range(0, 15));
            edges   = new_lvl & ~old_lvl;
            drive_in(new_lvl);
            if (edges != 4'd0) begin
                exp_q.push_back({edges, new_lvl});
                pop_check("rand_evt", got);
            end else begin
                repeat (8) @(negedge clk);
                check("rand_noevt", 64'(evt_valid), 64'd0);
            end
            repeat (2) @(posedge clk);
        end

        // Backpressure: nine single-bit edges with the consumer stalled.
        drive_in(4'b0000);
        repeat (3) @(posedge clk);
        for (int k = 0; k < 9; k++) begin
            b = 4'b0001 << 2'($urandom_range(0, 3));
            drive_in(b);
            exp_q.push_back({b, b});
            if (k < 8) begin
                repeat (10) @(posedge clk);
                #1 in_port = 4'b0000;
                repeat (2) @(posedge clk);
            end
        end
        repeat (10) @(negedge clk);
        check("full_valid", 64'(evt_valid), 64'd1);
        check("full_irq",   64'(pio_bus.pio_irq), 64'd1);
        check("full_idle",  64'(busy), 64'd0);
        for (int k = 0; k < 9; k++) pop_check("bp_evt", got);
        repeat (8) @(negedge clk);
        check("bp_drained", 64'(evt_valid), 64'd0);

        // Mask reconfiguration requested alongside an edge: CFG write goes first.
        drive_in(4'b0000);
        repeat (3) @(posedge clk);
        wr_log.delete();
        @(posedge clk);
        #1;
        in_port     = 4'b0001;
        cfg_mask    = 4'b0001;
        cfg_mask_wr = 1'b1;
        @(posedge clk);
        #1 cfg_mask_wr = 1'b0;
        exp_q.push_back({4'b0001, 4'b0001});
        pop_check("cfg_evt", got);
        check("cfg_wr_count", 64'(wr_log.size() >= 2), 64'd1);
        if (wr_log.size() >= 2) begin
            check("cfg_first_wr", 64'(wr_log[0]), 64'({2'd2, 32'd1}));
            check("cfg_clr_wr",   64'(wr_log[1]), 64'({2'd3, 32'd0}));
        end
        check("pio_mask_cfg", 64'(irq_mask), 64'd1);
        drive_in(4'b0101);
        repeat (12) @(negedge clk);
        check("masked_irq",   64'(pio_bus.pio_irq), 64'd0);
        check("masked_valid", 64'(evt_valid), 64'd0);
        check("masked_idle",  64'(busy), 64'd0);

        // Reset during CLR: stored entry flushed, in-flight event dropped.
        drive_in(4'b0000);
        repeat (2) @(posedge clk);
        drive_in(4'b0001);
        exp_q.push_back({4'b0001, 4'b0001});
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            found = evt_valid;
        end
        check("pre_rst_stored", 64'(found), 64'd1);
        drive_in(4'b0000);
        repeat (2) @(posedge clk);
        drive_in(4'b0001);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            found = pio_bus.pio_chipselect && !pio_bus.pio_write_n && (pio_bus.pio_address == 2'd3);
        end
        check("clr_seen", 64'(found), 64'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 64'(evt_valid), 64'd0);
        check("mid_rst_busy",  64'(busy), 64'd1);
        check("mid_rst_cs",    64'(pio_bus.pio_chipselect), 64'd0);
        reset_n = 1'b1;
        exp_q.delete();
        #1;
        check("post_rst_init", 64'({pio_bus.pio_chipselect, pio_bus.pio_write_n, pio_bus.pio_address, pio_bus.pio_writedata}),
              64'({1'b1, 1'b0, 2'd2, 32'hF}));
        seen_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (evt_valid) seen_cnt++;
        end
        check("rst_no_push", 64'(seen_cnt), 64'd0);
        check("rst_idle",    64'(busy), 64'd0);

`ifdef PIO_SVC_TIMESTAMP_EN
        begin
            logic [15:0] ts0, ts1;
            drive_in(4'b0000);
            repeat (3) @(posedge clk);
            drive_in(4'b0001);
            repeat (100) @(posedge clk);
            #1 in_port = 4'b0011;
            exp_q.push_back({4'b0001, 4'b0001});
            exp_q.push_back({4'b0010, 4'b0011});
            pop_check("ts_evt0", got);
            ts0 = got[15:0];
            pop_check("ts_evt1", got);
            ts1 = got[15:0];
            check("ts_delta", 64'(16'(ts1 - ts0)), 64'd100);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
